// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the stage pipeline: the default bubble/NOP
// word and the width helper used to size the occupancy count.
package pipe_pkg;

  // Default NOP fill; narrower pipelines take the low WIDTH bits.
  localparam logic [63:0] PIPE_NOP_DEFAULT = 64'h0;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register plus valid bit.
// Update priority is flush, then hold, then bubble, then load.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(PIPE_NOP_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             bubble_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  // Next-state selection by update priority.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      data_d  = NOP;
      valid_d = 1'b0;
    end else if (hold_i) begin
      data_d  = data_q;
      valid_d = valid_q;
    end else if (bubble_i) begin
      data_d  = NOP;
      valid_d = 1'b0;
    end else begin
      data_d  = data_i;
      valid_d = valid_i;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_chain.sv
// Linear chain of DEPTH stages with per-stage stall/flush, forwarding taps,
// an occupancy count and a saturating bubble-insert counter.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(PIPE_NOP_DEFAULT),
  localparam int              OCC_W = occ_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic                   in_ready,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [OCC_W-1:0]       occupancy,
  output logic [15:0]            bubble_cnt
);

  logic [DEPTH-1:0] hold_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic [DEPTH-1:0] valid_s;
  logic             bubble_any_s;
  logic [OCC_W-1:0] occ_s;
  logic [15:0]      bubble_cnt_q;
  logic [15:0]      bubble_cnt_d;

  // A stall anywhere downstream freezes this stage too.
  always_comb begin
    hold_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      hold_s[k] = |(stall >> k);
    end
  end

  assign in_ready = ~hold_s[0] & ~flush[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] up_data_s;
    logic             up_valid_s;
    logic             bubble_s;

    if (k == 0) begin : g_head
      assign up_data_s  = in_data;
      assign up_valid_s = in_valid;
      assign bubble_s   = 1'b0;
    end else begin : g_body
      assign up_data_s  = data_s[k-1];
      assign up_valid_s = valid_s[k-1];
      assign bubble_s   = hold_s[k-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH),
      .NOP   (NOP)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (hold_s[k]),
      .bubble_i (bubble_s),
      .flush_i  (flush[k]),
      .data_i   (up_data_s),
      .valid_i  (up_valid_s),
      .data_o   (data_s[k]),
      .valid_o  (valid_s[k])
    );

    assign stage_data[k*WIDTH +: WIDTH] = data_s[k];
  end

  assign stage_valid = valid_s;

  // Popcount of the registered valid bits.
  always_comb begin
    occ_s = {OCC_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      occ_s = occ_s + OCC_W'(valid_s[k]);
    end
  end

  assign occupancy = occ_s;

  // A bubble is taken where a stage runs free but its upstream neighbour holds.
  always_comb begin
    bubble_any_s = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (!flush[k] && !hold_s[k] && hold_s[k-1]) begin
        bubble_any_s = 1'b1;
      end else begin
        bubble_any_s = bubble_any_s;
      end
    end
  end

  // Saturating increment of the bubble counter.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_any_s && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed and randomized bench for pipe_chain (WIDTH=16, DEPTH=4, NOP=0),
// checked against an array-based model of the stage update rules.
module tb_pipe_chain;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic [3:0]  stall;
  logic [3:0]  flush;
  logic        in_ready;
  logic [63:0] stage_data;
  logic [3:0]  stage_valid;
  logic [2:0]  occupancy;
  logic [15:0] bubble_cnt;

  int errors;
  int checks;

  logic [15:0] m_data  [4];
  logic        m_valid [4];
  int          m_bub;

  pipe_chain #(
    .WIDTH (16),
    .DEPTH (4),
    .NOP   (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .stall       (stall),
    .flush       (flush),
    .in_ready    (in_ready),
    .stage_data  (stage_data),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model by the stage rules, compare everything.
  task automatic cycle(input logic rn, input logic iv, input logic [15:0] id,
                       input logic [3:0] st, input logic [3:0] fl);
    logic [15:0] nd [4];
    logic        nv [4];
    logic        hold [4];
    logic        bub_any;
    int          occ;
    rst_n = rn; in_valid = iv; in_data = id; stall = st; flush = fl;
    #1;
    for (int k = 0; k < 4; k++) hold[k] = ((st >> k) != 4'd0);
    chk("in_ready", 64'(in_ready), 64'(!hold[0] && !fl[0]));
    bub_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int km;
      km = (k == 0) ? 0 : k - 1;
      if (fl[k]) begin
        nd[k] = 16'h0000; nv[k] = 1'b0;
      end else if (hold[k]) begin
        nd[k] = m_data[k]; nv[k] = m_valid[k];
      end else if (k == 0) begin
        nd[k] = id; nv[k] = iv;
      end else if (hold[km]) begin
        nd[k] = 16'h0000; nv[k] = 1'b0; bub_any = 1'b1;
      end else begin
        nd[k] = m_data[km]; nv[k] = m_valid[km];
      end
    end
    if (!rn) begin
      for (int k = 0; k < 4; k++) begin m_data[k] = 16'h0000; m_valid[k] = 1'b0; end
      m_bub = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin m_data[k] = nd[k]; m_valid[k] = nv[k]; end
      if (bub_any && m_bub < 65535) m_bub++;
    end
    @(posedge clk);
    #1;
    occ = 0;
    for (int k = 0; k < 4; k++) occ += int'(m_valid[k]);
    chk("stage_valid", 64'(stage_valid),
        64'({m_valid[3], m_valid[2], m_valid[1], m_valid[0]}));
    chk("stage_data", stage_data, {m_data[3], m_data[2], m_data[1], m_data[0]});
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
  endtask

  initial begin
    int occ_before;
    errors = 0;
    checks = 0;
    m_bub  = 0;
    for (int k = 0; k < 4; k++) begin m_data[k] = 16'hFFFF; m_valid[k] = 1'b1; end
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; stall = 4'd0; flush = 4'd0;

    // Reset state.
    cycle(1'b0, 1'b1, 16'hDEAD, 4'b0000, 4'b0000);
    cycle(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b1111);
    chk("reset_valid", 64'(stage_valid), 64'h0);
    chk("reset_bub", 64'(bubble_cnt), 64'h0);

    // Four-item stream with no stall.
    cycle(1'b1, 1'b1, 16'h1111, 4'b0000, 4'b0000);
    cycle(1'b1, 1'b1, 16'h2222, 4'b0000, 4'b0000);
    cycle(1'b1, 1'b1, 16'h3333, 4'b0000, 4'b0000);
    cycle(1'b1, 1'b1, 16'h4444, 4'b0000, 4'b0000);
    chk("stream_data", stage_data, 64'h1111_2222_3333_4444);
    chk("stream_occ", 64'(occupancy), 64'd4);

    // Stall at stage 1 for two cycles on a full pipe; offered inputs dropped.
    cycle(1'b1, 1'b1, 16'h5555, 4'b0010, 4'b0000);
    cycle(1'b1, 1'b1, 16'h6666, 4'b0010, 4'b0000);
    chk("stall1_bub", 64'(bubble_cnt), 64'd2);
    chk("stall1_s2", 64'(stage_valid[2]), 64'd0);
    chk("stall1_s01", 64'(stage_data[31:0]), 64'h3333_4444);

    // Refill, then flush stages 0,1 while stage 1 stalls.
    cycle(1'b1, 1'b1, 16'h7777, 4'b0000, 4'b0000);
    cycle(1'b1, 1'b1, 16'h8888, 4'b0000, 4'b0000);
    occ_before = int'(occupancy);
    cycle(1'b1, 1'b1, 16'h9999, 4'b0010, 4'b0011);
    chk("flush_s01", 64'(stage_data[31:0]), 64'h0);
    chk("flush_occ", 64'(occupancy), 64'(occ_before - 3));
    chk("flush_bub", 64'(bubble_cnt), 64'd3);

    // Refill and stall the last stage for three cycles: everything freezes.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'(16'hA000 + i), 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'(16'hB000 + i), 4'b1000, 4'b0000);
    chk("stall3_data", stage_data, 64'hA000_A001_A002_A003);
    chk("stall3_occ", 64'(occupancy), 64'd4);

    // Reset mid-stream with stall on stage 2, then first input after release.
    cycle(1'b0, 1'b1, 16'hC0DE, 4'b0100, 4'b0000);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    cycle(1'b1, 1'b1, 16'hABCD, 4'b0000, 4'b0000);
    chk("midrst_in", 64'(stage_data[15:0]), 64'hABCD);

    // Randomized traffic with sparse stalls, flushes and resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] st;
      logic [3:0] fl;
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      fl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      cycle(($urandom_range(0, 60) != 0), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 65535)), st, fl);
    end

    // Sustained stall on stage 0: counter climbs to saturation and stays.
    cycle(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
    rst_n = 1'b1; stall = 4'b0001; flush = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("sat_fffe", 64'(bubble_cnt), 64'hFFFE);
    @(posedge clk); #1;
    chk("sat_ffff", 64'(bubble_cnt), 64'hFFFF);
    for (int i = 0; i < 4466; i++) @(posedge clk);
    #1;
    chk("sat_hold", 64'(bubble_cnt), 64'hFFFF);
    chk("sat_ready", 64'(in_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
